data_mem_arbiter: RTL and testbench
===================================

Name: data_mem_arbiter

Overview:
- Sequences and shares the single-port Data Memory between two requesters: port 0 (CPU load/store stage) and port 1 (debug/DMA loader).
- After reset it first runs a hardware clear sweep that writes zero to every word, then arbitrates requests with a valid/grant handshake.
- Read data is returned through a registered response path.
- Sits between the datapath MEM stage and the memory array, and owns all memory enables.

Parameters:
- ADDR_W, 64, address width of requester and memory ports
- DATA_W, 64, data width
- DEPTH, 64, number of memory words; addresses 0..DEPTH-1 are legal

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- m0_req  input  1  port 0 access request; held until m0_gnt
- m0_we  input  1  port 0 write (1) / read (0)
- m0_addr  input  ADDR_W  port 0 word address
- m0_wdata  input  DATA_W  port 0 write data
- m0_gnt  output  1  port 0 access performed this cycle
- m0_rvalid  output  1  port 0 read data valid
- m0_rdata  output  DATA_W  port 0 read data
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as port 0, for port 1
- mem_addr  output  ADDR_W  to memory Address
- mem_wdata  output  DATA_W  to memory WriteData
- mem_rdata  input  DATA_W  from memory ReadData (combinational read)
- mem_re  output  1  memory ReadEnable
- mem_we  output  1  memory WriteEnable
- init_done  output  1  clear sweep finished
- oob_err  output  1  one-cycle pulse on out-of-range access

Behaviour:
- Reset (rst low, asynchronous):
  - state=INIT, clr_ptr=0.
  - All gnt, rvalid, rdata, oob_err, init_done = 0.
  - Registered outputs are cleared immediately.
- INIT state:
  - Each cycle drives mem_we=1, mem_re=0, mem_addr=clr_ptr, mem_wdata=0, then clr_ptr+1.
  - The write at clr_ptr==DEPTH-1 is the last one; the next state is RUN.
  - The sweep takes exactly DEPTH cycles.
  - init_done rises on the first RUN cycle and stays 1 until reset.
  - m0_gnt/m1_gnt stay 0 and requests wait; no request is dropped.
- Reset asserted mid-sweep: the sweep restarts from address 0.
- RUN state:
  - Grants are combinational, from req and the priority state. At most one gnt per cycle.
  - The access happens in the grant cycle: mem_addr/mem_wdata/mem_we/mem_re are muxed from the granted port.
  - With no grant: mem_we=mem_re=0, mem_addr=0, mem_wdata=0.
- Writes: mem_we=gnt&we. Data is committed at the grant-cycle edge. No rvalid is produced.
- Reads:
  - mem_re=gnt&~we.
  - mem_rdata is captured at the grant-cycle edge.
  - mX_rvalid pulses on the next cycle (latency 1), with mX_rdata holding the captured value.
  - mX_rdata holds its value until the next read response for that port.
- Back-to-back: a port may be granted every cycle. Read responses pipeline with one response per cycle.
- Simultaneous requests: fixed priority, port 0 wins and port 1 is held off (see Optional Feature).
- Out-of-range (addr >= DEPTH):
  - gnt is still asserted and the handshake completes.
  - mem_we/mem_re are suppressed.
  - oob_err pulses the cycle after the grant.
  - For a read, rvalid pulses with rdata=0.
- Requester rule: req/we/addr/wdata must stay stable while req=1 and gnt=0. Dropping req before gnt withdraws the request.

Optional Feature:
- Macro DATA_MEM_ARB_RR_EN.
- Defined: round-robin arbitration.
  - A 1-bit last_grant register (reset 0) gives priority to the port not granted most recently, on each contended cycle.
  - Uncontended grants also update last_grant.
- Undefined: strict fixed priority, port 0 over port 1. No last_grant register is present.

Decomposition:
- Package data_mem_pkg holds:
  - default ADDR_W, DATA_W, DEPTH constants
  - state typedef {INIT, RUN}
  - port-index constants
- Sub-module arb2: 2-input grant logic with a priority input (fixed or round-robin), instantiated once.
- Muxing, the FSM and response registers stay in the top module.

Test Plan:
- Release reset, hold m0_req=1 read addr 5 → mem_we=1 for 64 cycles at addrs 0..63 with wdata 0; m0_gnt first at cycle 65; m0_rvalid next cycle with rdata=0.
- RUN: m0 writes 0xDEAD_BEEF to addr 10, then m1 reads addr 10 → m1_rvalid one cycle after m1_gnt, m1_rdata=0xDEAD_BEEF.
- Both ports request continuously for 8 cycles:
  - fixed priority: m0_gnt all 8 cycles, m1_gnt 0.
  - with DATA_MEM_ARB_RR_EN: grants alternate m0,m1,m0,…
- m1 read addr 64 → m1_gnt=1, mem_re=0, next cycle oob_err=1, m1_rvalid=1, m1_rdata=0.
- Assert rst low at sweep cycle 20 for 1 cycle → all outputs 0 immediately; sweep restarts at addr 0 and init_done rises 64 cycles after release.
- m0 back-to-back reads of addrs 1,2,3 on consecutive cycles (memory preloaded 1→0x11, 2→0x22, 3→0x33) → m0_rvalid high for 3 consecutive cycles with 0x11, 0x22, 0x33.

Source files
------------

// File: rtl/data_mem_arbiter_pkg.sv
// data_mem_pkg: shared constants and types for the data memory arbiter.
//   DEF_ADDR_W / DEF_DATA_W / DEF_DEPTH : default geometry
//   state_e                             : sequencing state (INIT sweep, RUN)
//   PORT0 / PORT1                       : requester indices used by the grant vector
package data_mem_pkg;

  localparam int DEF_ADDR_W = 64;
  localparam int DEF_DATA_W = 64;
  localparam int DEF_DEPTH  = 64;

  // INIT clears the array after reset; RUN serves requesters.
  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int PORT0 = 0;
  localparam int PORT1 = 1;

endpackage

// File: rtl/data_mem_arbiter_if.sv
// data_mem_arbiter_if: one requester port of the data memory arbiter.
//   req, we, addr, wdata : request from the requester
//   gnt                  : access performed this cycle
//   rvalid, rdata        : registered read response, one cycle after gnt
//
// Handshake: the requester raises req with we/addr/wdata and keeps all four
// stable until it samples gnt=1 at a rising edge; that edge completes the
// transfer. Dropping req before gnt withdraws the request. A read completes
// with rvalid=1 on the cycle after gnt, and rdata holds until the next read
// response on the same port. Writes produce no response.
interface data_mem_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/data_mem_arbiter_arb2.sv
// arb2: two-input combinational grant logic.
//   req  : request vector, bit i = port i
//   prio : index of the port that wins when both request
//   gnt  : one-hot (or zero) grant vector
// A lone request is always granted; prio only matters on contention.
module arb2 (
  input  logic [1:0] req,
  input  logic       prio,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (req == 2'b11) begin
      gnt[prio] = 1'b1;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares a single-port data memory between the CPU MEM
// stage (port 0) and the debug/DMA loader (port 1).
//
// After reset the block writes zero to every word (one word per cycle,
// DEPTH cycles), then arbitrates. The granted access is driven onto the
// memory bus in the grant cycle; read data is captured at the end of that
// cycle and returned on the next one.
//
// Ports:
//   clk, rst          : clock (rising edge), asynchronous active-low reset
//   m0, m1            : requester ports (data_mem_arbiter_if.slave)
//   mem_addr/mem_wdata: memory address / write data
//   mem_rdata         : memory read data (combinational read)
//   mem_re / mem_we   : memory read / write enables
//   init_done         : clear sweep finished, stays high until reset
//   oob_err           : one-cycle pulse the cycle after an out-of-range grant
//   dbg_state         : current sequencing state
//
// Build option: define DATA_MEM_ARB_RR_EN for round-robin arbitration
// (priority to the port not granted most recently). Without it port 0
// always wins contention.
module data_mem_arbiter
  import data_mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  data_mem_arbiter_if.slave m0,
  data_mem_arbiter_if.slave m1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_re,
  output logic              mem_we,
  output logic              init_done,
  output logic              oob_err,
  output state_e            dbg_state
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e            state_q, state_d;
  logic [PTR_W-1:0]  clr_ptr_q, clr_ptr_d;
  logic              clr_last;

  logic [1:0]        req_run;
  logic [1:0]        gnt;
  logic              arb_prio;
  logic              oob0, oob1;

  logic              init_done_q;
  logic              oob_err_q;
  logic              rvalid0_q, rvalid1_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;

  // Address range check per port; out-of-range accesses still handshake
  // but never reach the array.
  assign oob0 = (m0.addr >= ADDR_W'(DEPTH));
  assign oob1 = (m1.addr >= ADDR_W'(DEPTH));

  assign clr_last = (clr_ptr_q == PTR_W'(DEPTH - 1));

  // Requests are only visible to the arbiter once the sweep is finished;
  // until then they simply wait.
  assign req_run = {m1.req, m0.req} & {2{state_q == RUN}};

`ifdef DATA_MEM_ARB_RR_EN
  // Port granted most recently (contended or not); the other port wins
  // the next contended cycle.
  logic last_grant_q;

  assign arb_prio = ~last_grant_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_q <= 1'b0;
    end else if (gnt != 2'b00) begin
      last_grant_q <= gnt[PORT1];
    end
  end
`else
  assign arb_prio = 1'b0;
`endif

  arb2 u_arb2 (
    .req  (req_run),
    .prio (arb_prio),
    .gnt  (gnt)
  );

  // Next-state logic and the memory bus mux.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;

    case (state_q)
      INIT: begin
        // The enable is qualified with rst so nothing is written while
        // reset is held; the sweep starts at the first edge after release.
        mem_we    = rst;
        mem_addr  = ADDR_W'(clr_ptr_q);
        clr_ptr_d = clr_ptr_q + PTR_W'(1);
        if (clr_last) begin
          state_d   = RUN;
          clr_ptr_d = '0;
        end
      end
      RUN: begin
        if (gnt[PORT0]) begin
          mem_addr  = m0.addr;
          mem_wdata = m0.wdata;
          mem_we    = m0.we & ~oob0;
          mem_re    = ~m0.we & ~oob0;
        end else if (gnt[PORT1]) begin
          mem_addr  = m1.addr;
          mem_wdata = m1.wdata;
          mem_we    = m1.we & ~oob1;
          mem_re    = ~m1.we & ~oob1;
        end
      end
      default: begin
        state_d = INIT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= INIT;
      clr_ptr_q   <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_ptr_q   <= clr_ptr_d;
      // High from the first RUN cycle onwards.
      init_done_q <= (state_d == RUN);
    end
  end

  // Response path: capture at the grant-cycle edge, present next cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      oob_err_q <= 1'b0;
    end else begin
      rvalid0_q <= gnt[PORT0] & ~m0.we;
      rvalid1_q <= gnt[PORT1] & ~m1.we;
      if (gnt[PORT0] && !m0.we) begin
        rdata0_q <= oob0 ? '0 : mem_rdata;
      end
      if (gnt[PORT1] && !m1.we) begin
        rdata1_q <= oob1 ? '0 : mem_rdata;
      end
      oob_err_q <= (gnt[PORT0] & oob0) | (gnt[PORT1] & oob1);
    end
  end

  assign m0.gnt    = gnt[PORT0];
  assign m1.gnt    = gnt[PORT1];
  assign m0.rvalid = rvalid0_q;
  assign m1.rvalid = rvalid1_q;
  assign m0.rdata  = rdata0_q;
  assign m1.rdata  = rdata1_q;

  assign init_done = init_done_q;
  assign oob_err   = oob_err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: bench for data_mem_arbiter with a behavioural memory,
// a reference model of the arbitration/memory contents, and a scoreboard
// monitor for read responses and out-of-range pulses.
module tb_data_mem_arbiter;
  import data_mem_pkg::*;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;
  localparam int DEPTH  = 64;
  localparam int IDX_W  = $clog2(DEPTH);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  data_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m0_if ();
  data_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m1_if ();

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_re;
  logic              mem_we;
  logic              init_done;
  logic              oob_err;
  state_e            dbg_state;

  data_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .m0        (m0_if.slave),
    .m1        (m1_if.slave),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .init_done (init_done),
    .oob_err   (oob_err),
    .dbg_state (dbg_state)
  );

  // ---------------- memory array (environment) ----------------
  logic [DATA_W-1:0] mem_arr [DEPTH];

  initial begin
    for (int i = 0; i < DEPTH; i++) mem_arr[i] <= {$urandom, $urandom};
  end

  always @(posedge clk) begin
    if (mem_we && mem_addr < ADDR_W'(DEPTH)) mem_arr[mem_addr[IDX_W-1:0]] <= mem_wdata;
  end

  assign mem_rdata = (mem_addr < ADDR_W'(DEPTH)) ? mem_arr[mem_addr[IDX_W-1:0]] : '0;

  // ---------------- counters ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model / scoreboard queues ----------------
  logic [DATA_W-1:0] ref_mem [DEPTH];
  int                sweep_idx = 0;
  bit                model_run = 0;
  int                rr_last   = 0;

  logic [DATA_W-1:0] exp_q0[$];
  logic [DATA_W-1:0] exp_q1[$];
  int                exp_cyc0[$];
  int                exp_cyc1[$];
  int                exp_oob_q[$];

  // ---------------- driver state ----------------
  logic [1:0]        p_req = 2'b00;
  logic [1:0]        p_we  = 2'b00;
  logic [ADDR_W-1:0] p_addr [2];
  logic [DATA_W-1:0] p_wdata [2];

  task automatic drive_inputs();
    m0_if.req   = p_req[0];
    m0_if.we    = p_we[0];
    m0_if.addr  = p_addr[0];
    m0_if.wdata = p_wdata[0];
    m1_if.req   = p_req[1];
    m1_if.we    = p_we[1];
    m1_if.addr  = p_addr[1];
    m1_if.wdata = p_wdata[1];
  endtask

  // Which port the arbitration rules say gets this cycle (-1 = none).
  function automatic int model_pick();
    if (p_req == 2'b11) begin
`ifdef DATA_MEM_ARB_RR_EN
      return (rr_last == 0) ? 1 : 0;
`else
      return 0;
`endif
    end
    if (p_req[0]) return 0;
    if (p_req[1]) return 1;
    return -1;
  endfunction

  // One cycle: called just after a rising edge; drives, checks at the
  // falling edge, and returns just after the next rising edge.
  task automatic step();
    int                g;
    bit                oob;
    bit                rd;
    logic [DATA_W-1:0] d;
    drive_inputs();
    @(negedge clk);
    if (!model_run) begin
      check("sweep_init_done", init_done, 0);
      check("sweep_we", mem_we, 1);
      check("sweep_re", mem_re, 0);
      check("sweep_addr", mem_addr, 64'(sweep_idx));
      check("sweep_wdata", mem_wdata, 0);
      check("sweep_gnt", {m1_if.gnt, m0_if.gnt}, 0);
      sweep_idx++;
      if (sweep_idx == DEPTH) begin
        model_run = 1;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      end
    end else begin
      g = model_pick();
      check("run_init_done", init_done, 1);
      check("gnt0", m0_if.gnt, (g == 0));
      check("gnt1", m1_if.gnt, (g == 1));
      if (g >= 0) begin
        oob = (p_addr[g] >= ADDR_W'(DEPTH));
        rd  = !p_we[g];
        check("mem_we", mem_we, p_we[g] && !oob);
        check("mem_re", mem_re, rd && !oob);
        if (!oob) check("mem_addr", mem_addr, p_addr[g]);
        if (!oob && !rd) check("mem_wdata", mem_wdata, p_wdata[g]);
        if (oob) exp_oob_q.push_back(cyc + 1);
        if (rd) begin
          d = oob ? '0 : ref_mem[int'(p_addr[g])];
          if (g == 0) begin exp_q0.push_back(d); exp_cyc0.push_back(cyc + 1); end
          else        begin exp_q1.push_back(d); exp_cyc1.push_back(cyc + 1); end
        end else if (!oob) begin
          ref_mem[int'(p_addr[g])] = p_wdata[g];
        end
        rr_last  = g;
        p_req[g] = 1'b0;
      end else begin
        check("idle_mem_we", mem_we, 0);
        check("idle_mem_re", mem_re, 0);
        check("idle_mem_addr", mem_addr, 0);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int port, output int n);
    n = 0;
    while (p_req[port] && n < 300) begin
      step();
      n++;
    end
    if (p_req[port]) begin
      check("grant_timeout", 1, 0);
      p_req[port] = 1'b0;
    end
  endtask

  task automatic issue(input int port, input bit we, input int addr, input logic [DATA_W-1:0] wd);
    int n;
    p_req[port]   = 1'b1;
    p_we[port]    = we;
    p_addr[port]  = ADDR_W'(addr);
    p_wdata[port] = wd;
    wait_done(port, n);
  endtask

  // Asserts reset for one cycle starting just after a rising edge.
  task automatic pulse_reset();
    rst   = 1'b0;
    p_req = 2'b00;
    drive_inputs();
    #1;
    check("rst_init_done", init_done, 0);
    check("rst_rvalid0", m0_if.rvalid, 0);
    check("rst_rvalid1", m1_if.rvalid, 0);
    check("rst_rdata0", m0_if.rdata, 0);
    check("rst_rdata1", m1_if.rdata, 0);
    check("rst_oob_err", oob_err, 0);
    check("rst_gnt", {m1_if.gnt, m0_if.gnt}, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_state", 64'(dbg_state), 64'(INIT));
    @(posedge clk);
    #1;
    rst       = 1'b1;
    sweep_idx = 0;
    model_run = 0;
    rr_last   = 0;
    exp_q0.delete(); exp_q1.delete();
    exp_cyc0.delete(); exp_cyc1.delete(); exp_oob_q.delete();
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      if (m0_if.rvalid) begin
        if (exp_q0.size() == 0) check("rvalid0_unexpected", 1, 0);
        else begin
          check("rdata0", m0_if.rdata, exp_q0.pop_front());
          check("rvalid0_cycle", 64'(cyc), 64'(exp_cyc0.pop_front()));
        end
      end else if (exp_cyc0.size() > 0 && exp_cyc0[0] <= cyc) begin
        check("rvalid0_missing", 0, 1);
        void'(exp_q0.pop_front()); void'(exp_cyc0.pop_front());
      end
      if (m1_if.rvalid) begin
        if (exp_q1.size() == 0) check("rvalid1_unexpected", 1, 0);
        else begin
          check("rdata1", m1_if.rdata, exp_q1.pop_front());
          check("rvalid1_cycle", 64'(cyc), 64'(exp_cyc1.pop_front()));
        end
      end else if (exp_cyc1.size() > 0 && exp_cyc1[0] <= cyc) begin
        check("rvalid1_missing", 0, 1);
        void'(exp_q1.pop_front()); void'(exp_cyc1.pop_front());
      end
      if (oob_err) begin
        if (exp_oob_q.size() == 0) check("oob_err_unexpected", 1, 0);
        else check("oob_err_cycle", 64'(cyc), 64'(exp_oob_q.pop_front()));
      end else if (exp_oob_q.size() > 0 && exp_oob_q[0] <= cyc) begin
        check("oob_err_missing", 0, 1);
        void'(exp_oob_q.pop_front());
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    p_addr[0] = '0; p_addr[1] = '0; p_wdata[0] = '0; p_wdata[1] = '0;
    drive_inputs();
    @(posedge clk);
    #1;
    pulse_reset();

    // Sweep with a port-0 read of addr 5 waiting: first grant on cycle 65.
    p_req[0] = 1'b1; p_we[0] = 1'b0; p_addr[0] = 64'd5;
    wait_done(0, n);
    check("first_gnt_step", 64'(n), 65);
    check("run_state", 64'(dbg_state), 64'(RUN));

    // Write then read across ports.
    issue(0, 1'b1, 10, 64'hDEAD_BEEF);
    issue(1, 1'b0, 10, '0);
    step();

    // Contention for 8 cycles.
    p_req[1] = 1'b1; p_we[1] = 1'b0; p_addr[1] = 64'd20;
    for (int i = 0; i < 8; i++) begin
      if (!p_req[0]) begin
        p_req[0] = 1'b1; p_we[0] = 1'b0; p_addr[0] = ADDR_W'(i);
      end
      if (!p_req[1]) begin
        p_req[1] = 1'b1; p_we[1] = 1'b0; p_addr[1] = ADDR_W'(20 + i);
      end
      step();
    end
    wait_done(0, n);
    wait_done(1, n);

    // Out-of-range read and write.
    issue(1, 1'b0, 64, '0);
    issue(0, 1'b1, 70, 64'h1234);
    step();

    // Back-to-back reads after preload.
    issue(1, 1'b1, 1, 64'h11);
    issue(1, 1'b1, 2, 64'h22);
    issue(1, 1'b1, 3, 64'h33);
    for (int a = 1; a <= 3; a++) begin
      p_req[0] = 1'b1; p_we[0] = 1'b0; p_addr[0] = ADDR_W'(a);
      step();
    end
    step();

    // Random traffic.
    repeat (400) begin
      for (int p = 0; p < 2; p++) begin
        if (!p_req[p] && $urandom_range(0, 99) < 60) begin
          p_req[p]   = 1'b1;
          p_we[p]    = 1'($urandom_range(0, 1));
          p_addr[p]  = ADDR_W'($urandom_range(0, DEPTH + 3));
          p_wdata[p] = {$urandom, $urandom};
        end
      end
      step();
    end
    wait_done(0, n);
    wait_done(1, n);
    step();
    step();

    // Reset during RUN, then again mid-sweep; the sweep must restart at 0.
    pulse_reset();
    repeat (20) step();
    pulse_reset();
    p_req[1] = 1'b1; p_we[1] = 1'b0; p_addr[1] = 64'd10;
    wait_done(1, n);
    check("restart_gnt_step", 64'(n), 65);
    step();
    step();

    check("exp_q0_empty", 64'(exp_q0.size()), 0);
    check("exp_q1_empty", 64'(exp_q1.size()), 0);
    check("exp_oob_empty", 64'(exp_oob_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
